// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between an LFSR pattern source and lfsr_checker.
// The master drives the received stream and clear; the slave (checker) returns lock/error status.
interface lfsr_checker_if #(
  parameter int NUM_BITS     = 8,
  parameter int ERR_CNT_BITS = 16
);
  logic                    i_Clear;
  logic                    i_Data_DV;
  logic [NUM_BITS-1:0]     i_Data;
  logic                    o_Locked;
  logic                    o_Err;
  logic [ERR_CNT_BITS-1:0] o_Err_Count;
  logic [31:0]             o_Word_Count;

  modport master (
    output i_Clear, i_Data_DV, i_Data,
    input  o_Locked, o_Err, o_Err_Count, o_Word_Count
  );

  modport slave (
    input  i_Clear, i_Data_DV, i_Data,
    output o_Locked, o_Err, o_Err_Count, o_Word_Count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for an XNOR-feedback LFSR word stream: hunts for a seed,
// confirms LOCK_COUNT predicted words, then free-runs and counts mismatched words.
module lfsr_checker #(
  parameter int NUM_BITS     = 8,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_ERRS  = 4,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  lfsr_checker_if.slave bus
);

  // Tap k of the XAPP052 table maps to bit k-1 of the mask.
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]             TAP_MASK   = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0]     TAP_VEC    = TAP_MASK[NUM_BITS-1:0];
  localparam logic [7:0]              LOCK_LIM   = 8'(LOCK_COUNT);
  localparam logic [7:0]              UNLOCK_LIM = 8'(UNLOCK_ERRS);
  localparam logic [ERR_CNT_BITS-1:0] ERR_ONE    = {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};

  // Every table entry has 2 or 4 taps, so the XNOR chain reduces to an inverted XOR.
  function automatic logic [NUM_BITS-1:0] step(input logic [NUM_BITS-1:0] x);
    logic fb;
    fb = ~^(x & TAP_VEC);
    return {x[NUM_BITS-2:0], fb};
  endfunction

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t                  state_reg;
  logic [NUM_BITS-1:0]     exp_reg;
  logic [7:0]              match_cnt_reg;
  logic [7:0]              err_run_reg;
  logic                    locked_reg;
  logic                    err_reg;
  logic [ERR_CNT_BITS-1:0] err_count_reg;
  logic [31:0]             word_count_reg;

  logic                    data_all_ones;
  logic                    data_match;
  logic [NUM_BITS-1:0]     data_step;
  logic [NUM_BITS-1:0]     exp_step;

  assign data_all_ones = &bus.i_Data;
  assign data_match    = (bus.i_Data == exp_reg);
  assign data_step     = step(bus.i_Data);
  assign exp_step      = step(exp_reg);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg      <= HUNT;
      exp_reg        <= '0;
      match_cnt_reg  <= '0;
      err_run_reg    <= '0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      err_count_reg  <= '0;
      word_count_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      if (bus.i_Data_DV) begin
        unique case (state_reg)
          HUNT: begin
            if (!data_all_ones) begin
              exp_reg       <= data_step;
              match_cnt_reg <= '0;
              state_reg     <= SYNC;
            end
          end
          SYNC: begin
            if (data_match) begin
              exp_reg       <= data_step;
              match_cnt_reg <= match_cnt_reg + 8'd1;
              if (match_cnt_reg + 8'd1 == LOCK_LIM) begin
                state_reg   <= LOCKED;
                locked_reg  <= 1'b1;
                err_run_reg <= '0;
              end
            end else if (data_all_ones) begin
              match_cnt_reg <= '0;
              state_reg     <= HUNT;
            end else begin
              exp_reg       <= data_step;
              match_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            // Free-running prediction: a single corrupt word costs exactly one error.
            exp_reg <= exp_step;
            if (~&word_count_reg) word_count_reg <= word_count_reg + 32'd1;
            if (data_match) begin
              err_run_reg <= '0;
            end else begin
              err_reg     <= 1'b1;
              err_run_reg <= err_run_reg + 8'd1;
              if (~&err_count_reg) err_count_reg <= err_count_reg + ERR_ONE;
              if (err_run_reg + 8'd1 == UNLOCK_LIM) begin
                state_reg  <= HUNT;
                locked_reg <= 1'b0;
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
      // Clear wins over any increment made above in the same cycle.
      if (bus.i_Clear) begin
        err_count_reg  <= '0;
        word_count_reg <= '0;
      end
    end
  end

  assign bus.o_Locked     = locked_reg;
  assign bus.o_Err        = err_reg;
  assign bus.o_Err_Count  = err_count_reg;
  assign bus.o_Word_Count = word_count_reg;

endmodule
